// File: rtl/hyperbus_pkg.sv
// Shared HyperBus definitions: one-hot FSM state encoding, command/address (CA)
// bit positions, register-space addresses, CR0 defaults and a CA address helper.
package hyperbus_pkg;

    // One-hot state encoding, same style as the leader
    typedef enum logic [5:0] {
        StIdle    = 6'b000001,
        StCa      = 6'b000010,
        StLatency = 6'b000100,
        StWrite   = 6'b001000,
        StRead    = 6'b010000,
        StRegwr   = 6'b100000
    } hb_state_e;

    // Bit positions within the 48-bit CA; word 0 carries CA[47:32]
    localparam int unsigned CaRwBit     = 47;
    localparam int unsigned CaRegBit    = 46;
    localparam int unsigned CaLinearBit = 45;
    localparam int unsigned CaWord0Lsb  = 32;

    // Register-space word addresses
    localparam logic [31:0] RegAdrId0 = 32'h0000_0000;
    localparam logic [31:0] RegAdrId1 = 32'h0000_0001;
    localparam logic [31:0] RegAdrCr0 = 32'h0000_0800;
    localparam logic [31:0] RegAdrCr1 = 32'h0000_0801;

    localparam logic [15:0] Cr0Default     = 16'h8F1F;
    localparam logic [15:0] Cr1Value       = 16'h0002;
    localparam int unsigned Cr0FixedLatBit = 3;

    // Word address = {CA[44:16], CA[2:0]}; callers pass those slices directly
    function automatic logic [31:0] ca_word_addr(input logic [12:0] ca_44_32,
                                                 input logic [15:0] ca_31_16,
                                                 input logic [2:0]  ca_2_0);
        return {ca_44_32, ca_31_16, ca_2_0};
    endfunction

endpackage

// File: rtl/hyperbus_target_regs.sv
// HyperRAM register space: read-only ID0/ID1/CR1, writable CR0.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   we_i       - write strobe for the single register-write data word
//   adr_i      - register word address
//   wdat_i     - write data (only CR0 accepts it)
//   rdat_o     - read mux output for adr_i, zero for unmapped addresses
//   dbl_o      - CR0 fixed-latency bit (1 = always double latency)
module hyperbus_target_regs
    import hyperbus_pkg::*;
#(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter logic [15:0] ID0_VALUE   = 16'h0C81,
    parameter logic [15:0] ID1_VALUE   = 16'h0001,
    parameter logic [15:0] CR0_RESET   = Cr0Default
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   we_i,
    input  logic [ADDR_LENGTH-1:0] adr_i,
    input  logic [15:0]            wdat_i,
    output logic [15:0]            rdat_o,
    output logic                   dbl_o
);

    logic [31:0] adr32;
    logic [15:0] cr0_q, cr0_d;

    assign adr32 = 32'(adr_i);
    assign dbl_o = cr0_q[Cr0FixedLatBit];

    // Writes to anything other than CR0 are silently dropped
    always_comb begin
        cr0_d = cr0_q;
        if (we_i && (adr32 == RegAdrCr0)) begin
            cr0_d = wdat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cr0_q <= CR0_RESET;
        end else begin
            cr0_q <= cr0_d;
        end
    end

    always_comb begin
        rdat_o = 16'h0000;
        case (adr32)
            RegAdrId0: rdat_o = ID0_VALUE;
            RegAdrId1: rdat_o = ID1_VALUE;
            RegAdrCr0: rdat_o = cr0_q;
            RegAdrCr1: rdat_o = Cr1Value;
            default:   rdat_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/hyperbus_target.sv
// Word-level HyperBus target modelling a HyperRAM behind the leader's DDR IO layer.
// Accepts three CA words, signals latency on RWDS, then streams write words into
// a synchronous single-port memory or returns read words strobed with RWDS=2'b10.
// Ports:
//   clk, rstn               - clock (one HyperBus clock per cycle), sync active-low reset
//   hb_csn                  - chip select, active low; high aborts any transaction
//   hb_dq_i / hb_dq_o / _oe - deserialized DQ word in / out / drive enable
//   hb_rwds_i / _o / _oe    - RWDS pair in (1 = byte masked) / out / drive enable
//   mem_adr, mem_re, mem_we - memory word address, read strobe (data next cycle), write
//   mem_be, mem_wdat        - byte enables (~hb_rwds_i) and write data (hb_dq_i)
//   mem_rdat                - memory read data, valid the cycle after mem_re
module hyperbus_target
    import hyperbus_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TACC_COUNT  = 5,
    parameter int unsigned ADDR_LENGTH = 32,
    parameter logic [15:0] ID0_VALUE   = 16'h0C81,
    parameter logic [15:0] ID1_VALUE   = 16'h0001,
    parameter logic [15:0] CR0_RESET   = Cr0Default
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   hb_csn,
    input  logic [2*WIDTH-1:0]     hb_dq_i,
    output logic [2*WIDTH-1:0]     hb_dq_o,
    output logic                   hb_dq_oe,
    input  logic [1:0]             hb_rwds_i,
    output logic [1:0]             hb_rwds_o,
    output logic                   hb_rwds_oe,
    output logic [ADDR_LENGTH-1:0] mem_adr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [1:0]             mem_be,
    output logic [2*WIDTH-1:0]     mem_wdat,
    input  logic [2*WIDTH-1:0]     mem_rdat
);

    localparam int unsigned   LatW   = $clog2(2 * TACC_COUNT + 1);
    localparam logic [LatW-1:0] LatDbl = LatW'(2 * TACC_COUNT - 1);
    localparam logic [LatW-1:0] LatSgl = LatW'(TACC_COUNT - 1);

    hb_state_e              state_q, state_d;
    logic                   ca_idx_q, ca_idx_d;
    logic [15:0]            ca_w0_q, ca_w0_d;
    logic [15:0]            ca_w1_q, ca_w1_d;
    logic [LatW-1:0]        lat_q, lat_d;
    logic [ADDR_LENGTH-1:0] adr_q, adr_d, adr_inc;
    logic                   regwr_done_q, regwr_done_d;

    logic        is_read, is_reg, is_linear;
    logic        dbl;
    logic        reg_we;
    logic [15:0] reg_rdat;

    // CA word 0 is held for the whole transaction, so its flags decode directly
    assign is_read   = ca_w0_q[CaRwBit - CaWord0Lsb];
    assign is_reg    = ca_w0_q[CaRegBit - CaWord0Lsb];
    assign is_linear = ca_w0_q[CaLinearBit - CaWord0Lsb];

    assign reg_we = (state_q == StRegwr) && !regwr_done_q && !hb_csn;

    hyperbus_target_regs #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .ID0_VALUE   (ID0_VALUE),
        .ID1_VALUE   (ID1_VALUE),
        .CR0_RESET   (CR0_RESET)
    ) u_regs (
        .clk    (clk),
        .rstn   (rstn),
        .we_i   (reg_we),
        .adr_i  (adr_q),
        .wdat_i (hb_dq_i[15:0]),
        .rdat_o (reg_rdat),
        .dbl_o  (dbl)
    );

    // Wrapped bursts cycle within a 16-word block; upper bits stay put
    always_comb begin
        adr_inc = adr_q;
        if (is_linear) begin
            adr_inc = adr_q + ADDR_LENGTH'(1);
        end else begin
            adr_inc[3:0] = adr_q[3:0] + 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ca_idx_d     = ca_idx_q;
        ca_w0_d      = ca_w0_q;
        ca_w1_d      = ca_w1_q;
        lat_d        = lat_q;
        adr_d        = adr_q;
        regwr_done_d = regwr_done_q;
        if (hb_csn) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ca_w0_d  = hb_dq_i[15:0];
                    ca_idx_d = 1'b0;
                    state_d  = StCa;
                end
                StCa: begin
                    if (!ca_idx_q) begin
                        ca_w1_d  = hb_dq_i[15:0];
                        ca_idx_d = 1'b1;
                    end else begin
                        adr_d = ADDR_LENGTH'(ca_word_addr(ca_w0_q[12:0], ca_w1_q,
                                                          hb_dq_i[2:0]));
                        if (!is_read && is_reg) begin
                            state_d      = StRegwr;
                            regwr_done_d = 1'b0;
                        end else begin
                            state_d = StLatency;
                            lat_d   = dbl ? LatDbl : LatSgl;
                        end
                    end
                end
                StLatency: begin
                    if (lat_q == '0) begin
                        state_d = is_read ? StRead : StWrite;
                        // mem_re fires this cycle, so the next fetch is already +1
                        if (is_read && !is_reg) begin
                            adr_d = adr_inc;
                        end
                    end else begin
                        lat_d = lat_q - LatW'(1);
                    end
                end
                StWrite: adr_d = adr_inc;
                StRead: begin
                    if (!is_reg) begin
                        adr_d = adr_inc;
                    end
                end
                StRegwr: regwr_done_d = 1'b1;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            ca_idx_q     <= 1'b0;
            ca_w0_q      <= '0;
            ca_w1_q      <= '0;
            lat_q        <= '0;
            adr_q        <= '0;
            regwr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ca_idx_q     <= ca_idx_d;
            ca_w0_q      <= ca_w0_d;
            ca_w1_q      <= ca_w1_d;
            lat_q        <= lat_d;
            adr_q        <= adr_d;
            regwr_done_q <= regwr_done_d;
        end
    end

    // Outputs; hb_csn high gates every enable and strobe in the same cycle
    always_comb begin
        hb_dq_o    = '0;
        hb_dq_oe   = 1'b0;
        hb_rwds_o  = 2'b00;
        hb_rwds_oe = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_adr    = adr_q;
        mem_be     = ~hb_rwds_i;
        mem_wdat   = hb_dq_i;
        if (!hb_csn) begin
            unique case (state_q)
                StIdle, StCa: begin
                    hb_rwds_oe = 1'b1;
                    hb_rwds_o  = {2{dbl}};
                end
                StLatency: begin
                    mem_re = (lat_q == '0) && is_read && !is_reg;
                end
                StRead: begin
                    hb_dq_oe   = 1'b1;
                    hb_dq_o    = is_reg ? (2*WIDTH)'(reg_rdat) : mem_rdat;
                    hb_rwds_oe = 1'b1;
                    hb_rwds_o  = 2'b10;
                    mem_re     = !is_reg;
                end
                StWrite: mem_we = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_target.sv
// Self-checking bench for hyperbus_target: a transaction-level model predicts
// latency, address sequence, byte masking and register contents.
module tb_hyperbus_target;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned TACC  = 5;
    localparam int unsigned AL    = 32;
    localparam logic [15:0] ID0   = 16'h0C81;
    localparam logic [15:0] ID1   = 16'h0001;
    localparam logic [15:0] CR0R  = 16'h8F1F;

    logic          clk;
    logic          rstn;
    logic          hb_csn;
    logic [15:0]   hb_dq_i;
    logic [15:0]   hb_dq_o;
    logic          hb_dq_oe;
    logic [1:0]    hb_rwds_i;
    logic [1:0]    hb_rwds_o;
    logic          hb_rwds_oe;
    logic [AL-1:0] mem_adr;
    logic          mem_re;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdat;
    logic [15:0]   mem_rdat;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [15:0] cr0_m;
    logic [15:0] ref_mem [256];
    logic [1:0]  ref_vld [256];

    // Device RAM behind the target
    logic [15:0] env_mem [256];

    hyperbus_target #(
        .WIDTH       (WIDTH),
        .TACC_COUNT  (TACC),
        .ADDR_LENGTH (AL),
        .ID0_VALUE   (ID0),
        .ID1_VALUE   (ID1),
        .CR0_RESET   (CR0R)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hb_csn     (hb_csn),
        .hb_dq_i    (hb_dq_i),
        .hb_dq_o    (hb_dq_o),
        .hb_dq_oe   (hb_dq_oe),
        .hb_rwds_i  (hb_rwds_i),
        .hb_rwds_o  (hb_rwds_o),
        .hb_rwds_oe (hb_rwds_oe),
        .mem_adr    (mem_adr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdat   (mem_wdat),
        .mem_rdat   (mem_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_be[0]) env_mem[mem_adr[7:0]][7:0]  <= mem_wdat[7:0];
            if (mem_be[1]) env_mem[mem_adr[7:0]][15:8] <= mem_wdat[15:8];
        end
        if (mem_re) mem_rdat <= env_mem[mem_adr[7:0]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] reg_model(input logic [31:0] a);
        case (a)
            32'h0:   return ID0;
            32'h1:   return ID1;
            32'h800: return cr0_m;
            32'h801: return 16'h0002;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [47:0] make_ca(input bit rd, input bit rg, input bit lin,
                                            input logic [31:0] a);
        logic [47:0] ca;
        ca        = '0;
        ca[47]    = rd;
        ca[46]    = rg;
        ca[45]    = lin;
        ca[44:16] = a[31:3];
        ca[2:0]   = a[2:0];
        return ca;
    endfunction

    // One full transaction. stop_at >= 0 ends it at that data word: by deasserting
    // hb_csn, or (stop_rst) by pulsing reset during a fully masked write word.
    task automatic run_txn(input logic [47:0] ca, input int n, input int stop_at,
                           input bit stop_rst, input bit use_fixed,
                           input logic [15:0] fixed);
        bit          rd, rg, lin;
        logic [31:0] a, ea;
        logic [15:0] d, exp_d, vm;
        logic [1:0]  m;
        logic        exp_re;
        int          lat;
        rd  = ca[47];
        rg  = ca[46];
        lin = ca[45];
        a   = {ca[44:16], ca[2:0]};
        lat = (rg && !rd) ? 0 : (cr0_m[3] ? 2 * TACC : TACC);

        for (int i = 0; i < 3; i++) begin
            hb_csn    = 1'b0;
            hb_rwds_i = 2'b00;
            hb_dq_i   = (i == 0) ? ca[47:32] : ((i == 1) ? ca[31:16] : ca[15:0]);
            @(negedge clk);
            tests_run++;
            if ({hb_rwds_oe, hb_rwds_o, hb_dq_oe} !== {1'b1, {2{cr0_m[3]}}, 1'b0}) begin
                tests_failed++;
                $display("FAIL ca_rwds word%0d ca=%h: got oe=%b rwds=%b dq_oe=%b, want 1 %b 0",
                         i, ca, hb_rwds_oe, hb_rwds_o, hb_dq_oe, {2{cr0_m[3]}});
            end
            adv();
        end

        for (int k = 1; k <= lat; k++) begin
            hb_dq_i   = 16'($urandom);
            hb_rwds_i = rd ? 2'b00 : 2'($urandom);
            exp_re    = rd && !rg && (k == lat);
            @(negedge clk);
            tests_run++;
            if ({mem_we, mem_re, hb_dq_oe} !== {1'b0, exp_re, 1'b0}) begin
                tests_failed++;
                $display("FAIL latency cyc%0d/%0d ca=%h: got we=%b re=%b dq_oe=%b, want 0 %b 0",
                         k, lat, ca, mem_we, mem_re, hb_dq_oe, exp_re);
            end
            adv();
        end

        for (int j = 0; j < n; j++) begin
            ea = rg ? a : (lin ? a + 32'(j) : {a[31:4], a[3:0] + 4'(j)});
            if (j == stop_at && !stop_rst) begin
                hb_csn = 1'b1;
                @(negedge clk);
                tests_run++;
                if ({hb_dq_oe, hb_rwds_oe, mem_we, mem_re} !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL abort word%0d: got dq_oe=%b rwds_oe=%b we=%b re=%b, want 0",
                             j, hb_dq_oe, hb_rwds_oe, mem_we, mem_re);
                end
                adv();
                return;
            end
            if (rd) begin
                hb_dq_i   = 16'($urandom);
                hb_rwds_i = 2'b00;
                if (rg) begin
                    exp_d = reg_model(a);
                    vm    = 16'hFFFF;
                end else begin
                    exp_d = ref_mem[ea[7:0]];
                    vm    = {{8{ref_vld[ea[7:0]][1]}}, {8{ref_vld[ea[7:0]][0]}}};
                end
                @(negedge clk);
                tests_run++;
                if ({hb_dq_oe, hb_rwds_oe, hb_rwds_o, mem_re} !== {1'b1, 1'b1, 2'b10, !rg}
                    || ((hb_dq_o ^ exp_d) & vm) !== 16'h0000) begin
                    tests_failed++;
                    $display("FAIL read word%0d adr=%h: got oe=%b/%b rwds=%b re=%b dq=%h, want 1/1 10 %b dq=%h (mask %h)",
                             j, ea, hb_dq_oe, hb_rwds_oe, hb_rwds_o, mem_re, hb_dq_o,
                             !rg, exp_d, vm);
                end
                adv();
            end else if (rg) begin
                d         = use_fixed ? fixed : 16'($urandom);
                hb_dq_i   = d;
                hb_rwds_i = 2'b00;
                @(negedge clk);
                tests_run++;
                if ({mem_we, hb_dq_oe, hb_rwds_oe} !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL regwr word%0d: got we=%b dq_oe=%b rwds_oe=%b, want 0",
                             j, mem_we, hb_dq_oe, hb_rwds_oe);
                end
                adv();
                if (j == 0 && a == 32'h800) cr0_m = d;
            end else begin
                d = use_fixed ? fixed : 16'($urandom);
                m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                if (stop_rst && j == stop_at) begin
                    m    = 2'b11;
                    rstn = 1'b0;
                end
                hb_dq_i   = d;
                hb_rwds_i = m;
                @(negedge clk);
                tests_run++;
                if ({mem_we, mem_adr, mem_be, mem_wdat} !== {1'b1, ea, ~m, d}) begin
                    tests_failed++;
                    $display("FAIL write word%0d: got we=%b adr=%h be=%b wdat=%h, want 1 %h %b %h",
                             j, mem_we, mem_adr, mem_be, mem_wdat, ea, ~m, d);
                end
                if (!m[0]) begin
                    ref_mem[ea[7:0]][7:0] = d[7:0];
                    ref_vld[ea[7:0]][0]   = 1'b1;
                end
                if (!m[1]) begin
                    ref_mem[ea[7:0]][15:8] = d[15:8];
                    ref_vld[ea[7:0]][1]    = 1'b1;
                end
                adv();
                if (stop_rst && j == stop_at) begin
                    rstn   = 1'b1;
                    hb_csn = 1'b1;
                    @(negedge clk);
                    tests_run++;
                    if ({mem_we, mem_re, hb_dq_oe, hb_rwds_oe, mem_adr} !== {4'b0000, 32'h0}) begin
                        tests_failed++;
                        $display("FAIL reset_mid_burst: got we=%b re=%b oe=%b/%b adr=%h, want 0",
                                 mem_we, mem_re, hb_dq_oe, hb_rwds_oe, mem_adr);
                    end
                    adv();
                    cr0_m = CR0R;
                    return;
                end
            end
        end

        hb_csn = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({hb_dq_oe, hb_rwds_oe, mem_we, mem_re} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL end_idle ca=%h: got dq_oe=%b rwds_oe=%b we=%b re=%b, want 0",
                     ca, hb_dq_oe, hb_rwds_oe, mem_we, mem_re);
        end
        adv();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        hb_csn    = 1'b1;
        hb_dq_i   = '0;
        hb_rwds_i = '0;
        adv();
        adv();
        @(negedge clk);
        tests_run++;
        if ({hb_dq_oe, hb_rwds_oe, mem_we, mem_re, hb_dq_o, hb_rwds_o, mem_adr}
            !== {4'b0000, 16'h0, 2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset: got oe=%b/%b we=%b re=%b dq=%h rwds=%b adr=%h, want all 0",
                     hb_dq_oe, hb_rwds_oe, mem_we, mem_re, hb_dq_o, hb_rwds_o, mem_adr);
        end
        rstn  = 1'b1;
        cr0_m = CR0R;
        adv();
    endtask

    task automatic test_mem_write();
        run_txn(48'h2000_0000_0005, 3, -1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_mem_read();
        run_txn(48'hA000_0000_0005, 3, -1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reg_read();
        run_txn(48'hC000_0000_0000, 2, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0000_0001, 1, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0100_0000, 1, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0100_0001, 1, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0000_0005, 1, -1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reg_write();
        run_txn(48'h6000_0100_0000, 1, -1, 1'b0, 1'b1, 16'h8F17);
        run_txn(48'hA000_0000_0005, 3, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'h6000_0100_0001, 1, -1, 1'b0, 1'b1, 16'hFFFF);
        run_txn(48'h6000_0000_0000, 1, -1, 1'b0, 1'b1, 16'h1234);
        run_txn(48'hC000_0100_0001, 1, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0000_0000, 1, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0100_0000, 1, -1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_wrap();
        run_txn(48'h0000_0003_0006, 4, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'h8000_0003_0006, 4, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hA000_0003_0004, 6, -1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_abort();
        hb_csn    = 1'b0;
        hb_rwds_i = 2'b00;
        hb_dq_i   = 16'hA000;
        adv();
        hb_dq_i = 16'h0000;
        adv();
        hb_csn = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({hb_rwds_oe, hb_dq_oe, mem_we, mem_re} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL abort_ca: got rwds_oe=%b dq_oe=%b we=%b re=%b, want 0",
                     hb_rwds_oe, hb_dq_oe, mem_we, mem_re);
        end
        adv();
        run_txn(48'hA000_0000_0005, 2, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hA000_0003_0000, 4, 2, 1'b0, 1'b0, 16'h0);
        run_txn(48'h8000_0003_0006, 3, -1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int          kind;
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 200));
            if (kind == 0) begin
                run_txn(make_ca(1'b0, 1'b1, 1'b1, 32'h800), 1, -1, 1'b0, 1'b1,
                        16'($urandom));
            end else if (kind == 1) begin
                case ($urandom_range(0, 4))
                    0:       a = 32'h0;
                    1:       a = 32'h1;
                    2:       a = 32'h800;
                    3:       a = 32'h801;
                    default: a = 32'($urandom_range(2, 255));
                endcase
                run_txn(make_ca(1'b1, 1'b1, 1'b1, a), $urandom_range(1, 3), -1, 1'b0,
                        1'b0, 16'h0);
            end else begin
                run_txn(make_ca(kind >= 6, 1'b0, 1'($urandom_range(0, 1)), a),
                        $urandom_range(1, 8), -1, 1'b0, 1'b0, 16'h0);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        run_txn(48'h6000_0100_0000, 1, -1, 1'b0, 1'b1, 16'h8F10);
        run_txn(48'h2000_0004_0000, 4, 1, 1'b1, 1'b0, 16'h0);
        run_txn(48'hA000_0004_0000, 2, -1, 1'b0, 1'b0, 16'h0);
        run_txn(48'hC000_0100_0000, 1, -1, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'h0;
            ref_vld[i] = 2'b00;
        end
        cr0_m = CR0R;
        test_reset();
        test_mem_write();
        test_mem_read();
        test_reg_read();
        test_reg_write();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
